tile_sequencer: RTL and testbench

- Instruction sequencer for one 8x8 weight-stationary tile pass of `core`.
- On `start`, it walks every kernel index (kij) through five phases:
  - load weights from activation/weight SRAM (xmem) into L0, then into the PE array;
  - stream activations through the array;
  - drain the OFIFO into psum SRAM.
- It drives the SRAM control pins (CEN/WEN/A) and the corelet strobes that make up `core`'s 34-bit `inst` word; it has no datapath of its own.

---
 rtl/tile_pkg.sv | 21 ++
 rtl/tile_sequencer_if.sv | 31 +++
 rtl/sram_port_drv.sv | 34 +++
 rtl/tile_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_tile_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared types and defaults for the tile pass sequencer.
package tile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WL0,
    WLOAD,
    AL0,
    EXEC,
    DRAIN,
    PSUM,
    FIN
  } tile_state_e;

  localparam int W_BASE_DEF  = 1024;
  localparam int MAX_KIJ     = 9;
  localparam int MAX_NIJ     = 36;
  localparam int XMEM_AW_DEF = 11;
  localparam int PMEM_AW_DEF = 11;

endpackage

// File: rtl/tile_sequencer_if.sv
// SRAM control pins and corelet strobes that form core's instruction word.
interface tile_sequencer_if #(
  parameter int XMEM_AW = tile_pkg::XMEM_AW_DEF,
  parameter int PMEM_AW = tile_pkg::PMEM_AW_DEF
);
  logic               CEN_xmem;
  logic               WEN_xmem;
  logic [XMEM_AW-1:0] A_xmem;
  logic               CEN_pmem;
  logic               WEN_pmem;
  logic [PMEM_AW-1:0] A_pmem;
  logic               l0_wr;
  logic               l0_rd;
  logic               load;
  logic               execute;
  logic               ofifo_rd;
  logic               ofifo_valid;
  logic               acc;

  modport master (
    output CEN_xmem, WEN_xmem, A_xmem, CEN_pmem, WEN_pmem, A_pmem,
    output l0_wr, l0_rd, load, execute, ofifo_rd, acc,
    input  ofifo_valid
  );

  modport slave (
    input  CEN_xmem, WEN_xmem, A_xmem, CEN_pmem, WEN_pmem, A_pmem,
    input  l0_wr, l0_rd, load, execute, ofifo_rd, acc,
    output ofifo_valid
  );
endinterface

// File: rtl/sram_port_drv.sv
// Registers CEN/WEN/A for one SRAM; address holds while idle. rd_vld_p2 marks read data one cycle later.
module sram_port_drv
  import tile_pkg::*;
#(
  parameter int AW = XMEM_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_p0,
  input  logic          wr_p0,
  input  logic [AW-1:0] addr_p0,
  output logic          cen_p1,
  output logic          wen_p1,
  output logic [AW-1:0] a_p1,
  output logic          rd_vld_p2
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cen_p1    <= 1'b1;
      wen_p1    <= 1'b1;
      a_p1      <= '0;
      rd_vld_p2 <= 1'b0;
    end else begin
      // p0 -> p1: pin registers
      cen_p1 <= ~req_p0;
      wen_p1 <= ~(req_p0 & wr_p0);
      if (req_p0) a_p1 <= addr_p0;
      // p1 -> p2: SRAM read latency
      rd_vld_p2 <= ~cen_p1 & wen_p1;
    end
  end

endmodule

// File: rtl/tile_sequencer.sv
// Walks every kij of one 8x8 weight-stationary tile pass: WL0, WLOAD, AL0, EXEC, DRAIN/PSUM.
// Optional TILE_SEQ_PERF_CNT_EN adds cycle_cnt, a saturating busy-cycle counter.
module tile_sequencer
  import tile_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int XMEM_AW   = XMEM_AW_DEF,
  parameter int PMEM_AW   = PMEM_AW_DEF,
  parameter int W_BASE    = W_BASE_DEF,
  parameter int DRAIN_MAX = 64
) (
  input  logic             clk,
  input  logic             reset,
  tile_sequencer_if.master bus,
  input  logic             start,
  input  logic [3:0]       num_kij,
  input  logic [5:0]       num_nij,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef TILE_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]      cycle_cnt
`endif
);

  localparam int CNT_W = $clog2(DRAIN_MAX + ROW + COL + MAX_NIJ);

  tile_state_e        state, nxt;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [3:0]         kij, nxt_kij, nkij;
  logic [5:0]         nnij;
  logic               accept, last_nij, more_kij;

  logic               x_req_p0, p_req_p0;
  logic [XMEM_AW-1:0] x_addr_p0;
  logic [PMEM_AW-1:0] p_addr_p0;
  logic               l0_rd_p0, load_p0, exec_p0, pop_p0, acc_p0, fin_p0, tmo_p0;
  logic               l0_rd_p1, load_p1, exec_p1, pop_p1, acc_p1;
  logic               x_cen_p1, x_wen_p1, p_cen_p1, p_wen_p1, l0_wr_p2;
  logic               unused_pmem_vld;
  logic [XMEM_AW-1:0] x_a_p1;
  logic [PMEM_AW-1:0] p_a_p1;

  assign accept   = (state == IDLE) && start;
  assign last_nij = (CNT_W'(nnij) == cnt + CNT_W'(1));
  assign more_kij = ({1'b0, kij} + 5'd1) < {1'b0, nkij};

  always_comb begin
    nxt       = state;
    nxt_cnt   = cnt;
    nxt_kij   = kij;
    x_req_p0  = 1'b0;
    x_addr_p0 = '0;
    p_req_p0  = 1'b0;
    p_addr_p0 = '0;
    l0_rd_p0  = 1'b0;
    load_p0   = 1'b0;
    exec_p0   = 1'b0;
    pop_p0    = 1'b0;
    acc_p0    = 1'b0;
    fin_p0    = 1'b0;
    tmo_p0    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_cnt = '0;
          nxt_kij = '0;
          nxt     = (num_kij == 4'd0 || num_nij == 6'd0) ? FIN : WL0;
        end
      end
      WL0: begin
        x_req_p0  = 1'b1;
        x_addr_p0 = XMEM_AW'(W_BASE + COL * int'(kij) + int'(cnt));
        if (cnt == CNT_W'(ROW - 1)) begin
          nxt     = WLOAD;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      WLOAD: begin
        load_p0  = 1'b1;
        l0_rd_p0 = (cnt < CNT_W'(ROW));
        if (cnt == CNT_W'(ROW + COL - 1)) begin
          nxt     = AL0;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      AL0: begin
        x_req_p0  = 1'b1;
        x_addr_p0 = XMEM_AW'(cnt);
        if (last_nij) begin
          nxt     = EXEC;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      EXEC: begin
        l0_rd_p0 = 1'b1;
        exec_p0  = 1'b1;
        if (last_nij) begin
          nxt     = DRAIN;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      DRAIN: begin
        if (bus.ofifo_valid) begin
          nxt     = PSUM;
          nxt_cnt = '0;
        end else if (cnt == CNT_W'(DRAIN_MAX - 1)) begin
          tmo_p0 = 1'b1;
          nxt    = IDLE;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      PSUM: begin
        // a missing OFIFO row stalls the pop and holds nij
        if (bus.ofifo_valid) begin
          pop_p0    = 1'b1;
          p_req_p0  = 1'b1;
          p_addr_p0 = PMEM_AW'(cnt);
          acc_p0    = (kij != 4'd0);
          if (last_nij) begin
            nxt_cnt = '0;
            if (more_kij) begin
              nxt_kij = kij + 4'd1;
              nxt     = WL0;
            end else nxt = FIN;
          end else nxt_cnt = cnt + CNT_W'(1);
        end
      end
      FIN: begin
        fin_p0 = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      kij      <= '0;
      nkij     <= '0;
      nnij     <= '0;
      l0_rd_p1 <= 1'b0;
      load_p1  <= 1'b0;
      exec_p1  <= 1'b0;
      pop_p1   <= 1'b0;
      acc_p1   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      kij   <= nxt_kij;
      if (accept) begin
        nkij <= num_kij;
        nnij <= num_nij;
      end
      // p0 -> p1: strobe registers
      l0_rd_p1 <= l0_rd_p0;
      load_p1  <= load_p0;
      exec_p1  <= exec_p0;
      pop_p1   <= pop_p0;
      acc_p1   <= acc_p0;
      busy     <= (nxt != IDLE);
      done     <= fin_p0 | tmo_p0;
      if (accept) err <= 1'b0;
      else if (tmo_p0) err <= 1'b1;
    end
  end

  sram_port_drv #(.AW(XMEM_AW)) u_xmem (
    .clk       (clk),
    .reset     (reset),
    .req_p0    (x_req_p0),
    .wr_p0     (1'b0),
    .addr_p0   (x_addr_p0),
    .cen_p1    (x_cen_p1),
    .wen_p1    (x_wen_p1),
    .a_p1      (x_a_p1),
    .rd_vld_p2 (l0_wr_p2)
  );

  sram_port_drv #(.AW(PMEM_AW)) u_pmem (
    .clk       (clk),
    .reset     (reset),
    .req_p0    (p_req_p0),
    .wr_p0     (1'b1),
    .addr_p0   (p_addr_p0),
    .cen_p1    (p_cen_p1),
    .wen_p1    (p_wen_p1),
    .a_p1      (p_a_p1),
    .rd_vld_p2 (unused_pmem_vld)
  );

  assign bus.CEN_xmem = x_cen_p1;
  assign bus.WEN_xmem = x_wen_p1;
  assign bus.A_xmem   = x_a_p1;
  assign bus.CEN_pmem = p_cen_p1;
  assign bus.WEN_pmem = p_wen_p1;
  assign bus.A_pmem   = p_a_p1;
  assign bus.l0_wr    = l0_wr_p2;
  assign bus.l0_rd    = l0_rd_p1;
  assign bus.load     = load_p1;
  assign bus.execute  = exec_p1;
  assign bus.ofifo_rd = pop_p1;
  assign bus.acc      = acc_p1;

`ifdef TILE_SEQ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else if (accept) cycle_cnt <= '0;
    else if (busy) cycle_cnt <= sat_inc16(cycle_cnt);
  end
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: event logs on the instruction pins compared with a loop-built reference.
module tb_tile_sequencer;
  localparam int ROW       = 8;
  localparam int COL       = 8;
  localparam int W_BASE    = 1024;
  localparam int DRAIN_MAX = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_kij = '0;
  logic [5:0] num_nij = '0;
  logic       busy, done, err;
`ifdef TILE_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  // 0: valid tied high, 1: random, 2: tied low, 3: manual
  int   vmode = 0;
  logic v_manual = 1'b1;
  logic rnd_v = 1'b1;

  int n_total = 0, n_bad = 0;
  int cyc = 0, n_done = 0, n_l0wr = 0, n_l0rd = 0, n_load = 0, n_exec = 0, n_pop = 0;
  int rd_mis = 0, done_bad = 0, n_busy = 0, last_exec_cyc = 0, done_cyc = 0;
  logic prev_busy = 1'b0;
  int xq[$];
  int pq[$];

  tile_sequencer_if bif ();
  assign bif.ofifo_valid = (vmode == 0) || (vmode == 1 && rnd_v) || (vmode == 3 && v_manual);

  tile_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bif.master),
    .start   (start),
    .num_kij (num_kij),
    .num_nij (num_nij),
    .busy    (busy),
    .done    (done),
    .err     (err)
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_v = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    cyc++;
    if (!bif.CEN_xmem && bif.WEN_xmem) xq.push_back(int'(bif.A_xmem));
    if (!bif.CEN_pmem && !bif.WEN_pmem) pq.push_back(int'(bif.acc) * 1000 + int'(bif.A_pmem));
    if (bif.ofifo_rd != (!bif.CEN_pmem && !bif.WEN_pmem)) rd_mis++;
    if (bif.acc && bif.CEN_pmem) rd_mis++;
    if (bif.l0_wr) n_l0wr++;
    if (bif.l0_rd) n_l0rd++;
    if (bif.load) n_load++;
    if (bif.ofifo_rd) n_pop++;
    if (bif.execute) begin
      n_exec++;
      last_exec_cyc = cyc;
    end
    if (busy) n_busy++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (busy || !prev_busy) done_bad++;
    end
    prev_busy = busy;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    xq.delete();
    pq.delete();
    n_done = 0; n_l0wr = 0; n_l0rd = 0; n_load = 0; n_exec = 0; n_pop = 0;
    rd_mis = 0; done_bad = 0; n_busy = 0;
  endtask

  task automatic check_rst_pins(input string tag);
    check({tag, ".ctl"}, {bif.CEN_xmem, bif.WEN_xmem, bif.CEN_pmem, bif.WEN_pmem,
                          bif.l0_wr, bif.l0_rd, bif.load, bif.execute, bif.ofifo_rd,
                          bif.acc, busy, done, err}, 13'b1111_0000_00000);
    check({tag, ".a_xmem"}, bif.A_xmem, 0);
    check({tag, ".a_pmem"}, bif.A_pmem, 0);
`ifdef TILE_SEQ_PERF_CNT_EN
    check({tag, ".cyc_cnt"}, cycle_cnt, 0);
`endif
  endtask

  task automatic run_job(input int nk, input int nn, input int mode, input bit poke, input string tag);
    int  xe[$];
    int  pe[$];
    int  eff_k, nerr, budget, s_cyc;
    bit  tmo, degen, stalled;
    tmo     = (mode == 2);
    degen   = (nk == 0 || nn == 0);
    eff_k   = degen ? 0 : (tmo ? 1 : nk);
    stalled = 1'b0;
    for (int k = 0; k < eff_k; k++) begin
      for (int c = 0; c < COL; c++) xe.push_back(W_BASE + k * COL + c);
      for (int n = 0; n < nn; n++) xe.push_back(n);
      if (!tmo) for (int n = 0; n < nn; n++) pe.push_back((k != 0 ? 1000 : 0) + n);
    end

    clear_log();
    vmode    = mode;
    v_manual = 1'b1;
    @(posedge clk); #1;
    num_kij = 4'(nk);
    num_nij = 6'(nn);
    start   = 1'b1;
    s_cyc   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_rise"}, busy, 1);
    check({tag, ".err_clr"}, err, 0);

    budget = 0;
    while (n_done == 0 && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
      if (poke) begin
        start = (budget == 30);
        if (budget == 30) num_kij = 4'd7;
      end
      if (mode == 3 && !stalled && !bif.CEN_pmem && bif.A_pmem == 2) begin
        stalled  = 1'b1;
        v_manual = 1'b0;
        @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          check({tag, ".stall_rd"}, bif.ofifo_rd, 0);
          check({tag, ".stall_cen"}, bif.CEN_pmem, 1);
          check({tag, ".stall_addr"}, bif.A_pmem, 2);
        end
        v_manual = 1'b1;
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (mode == 3) check({tag, ".stall_hit"}, stalled, 1);

    check({tag, ".done_cnt"}, n_done, 1);
    check({tag, ".done_busy"}, done_bad, 0);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".err"}, err, tmo);
    check({tag, ".rd_vs_wr"}, rd_mis, 0);

    nerr = (xq.size() > xe.size()) ? xq.size() - xe.size() : xe.size() - xq.size();
    for (int i = 0; i < xq.size() && i < xe.size(); i++) if (xq[i] != xe[i]) nerr++;
    check({tag, ".x_cnt"}, xq.size(), xe.size());
    check({tag, ".x_seq_err"}, nerr, 0);

    nerr = (pq.size() > pe.size()) ? pq.size() - pe.size() : pe.size() - pq.size();
    for (int i = 0; i < pq.size() && i < pe.size(); i++) if (pq[i] != pe[i]) nerr++;
    check({tag, ".p_cnt"}, pq.size(), pe.size());
    check({tag, ".p_seq_err"}, nerr, 0);

    check({tag, ".l0_wr"}, n_l0wr, eff_k * (ROW + nn));
    check({tag, ".l0_rd"}, n_l0rd, eff_k * (ROW + nn));
    check({tag, ".load"}, n_load, eff_k * (ROW + COL));
    check({tag, ".exec"}, n_exec, eff_k * nn);
    check({tag, ".pops"}, n_pop, tmo ? 0 : eff_k * nn);
    if (tmo) check({tag, ".tmo_gap"}, done_cyc - last_exec_cyc, DRAIN_MAX);
    if (degen) begin
      check({tag, ".done_at"}, done_cyc - s_cyc, 3);
      check({tag, ".busy_cyc"}, n_busy, 1);
    end
`ifdef TILE_SEQ_PERF_CNT_EN
    check({tag, ".cyc_cnt"}, cycle_cnt, n_busy);
`endif
  endtask

  initial begin
    int budget, nk, nn;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_rst_pins("por");
    reset = 1'b1;
    @(posedge clk); #1;

    run_job(1, 4, 0, 1'b0, "k1n4");
    run_job(9, 36, 0, 1'b0, "k9n36");
    check("k9n36.k8_first", (xq.size() > 359) ? xq[352] : -1, 1088);
    check("k9n36.k8_last", (xq.size() > 359) ? xq[359] : -1, 1095);
    run_job(1, 36, 3, 1'b0, "stall");
    run_job(1, 4, 2, 1'b0, "tmo");
    repeat (5) @(posedge clk);
    #1;
    check("tmo.err_sticky", err, 1);
    run_job(1, 2, 0, 1'b0, "after_tmo");
    run_job(2, 10, 1, 1'b1, "poke");

    // abort during EXEC of kij=3
    clear_log();
    vmode   = 0;
    num_kij = 4'd5;
    num_nij = 6'd6;
    start   = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 0;
    while (n_exec < 3 * 6 + 2 && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("midrst.in_exec", bif.execute, 1);
    reset = 1'b0;
    #1;
    check_rst_pins("midrst");
    repeat (2) @(posedge clk);
    #1;
    check("midrst.no_done", n_done, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    run_job(2, 3, 1, 1'b0, "post_rst");

    run_job(3, 0, 0, 1'b0, "nn0");
    run_job(0, 5, 0, 1'b0, "nk0");

    for (int j = 0; j < 4; j++) begin
      nk = $urandom_range(1, 9);
      nn = $urandom_range(1, 36);
      run_job(nk, nn, 1, 1'b0, $sformatf("rnd%0d_k%0dn%0d", j, nk, nn));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
